// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: streams a byte payload out as a GMII frame with
// preamble/SFD, zero padding to MIN_FRAME, optional CRC-32 FCS and IFG.
// Ports: gmii_tx_clk, reset_n (async, active-low); s_tdata/s_tvalid/
//   s_tlast/s_tuser/s_tready upstream byte stream; gmii_txd/gmii_tx_en/
//   gmii_tx_er registered GMII outputs; busy, frame_done, underrun status.
// Build option: define GMII_TX_FRAMER_FCS_EN to append the FCS here;
//   otherwise the upstream source supplies it and no CRC logic is built.
module gmii_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic       gmii_tx_clk,
  input  logic       reset_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic       s_tready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_SFD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_PAD  = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_DROP = 3'd6;
  localparam logic [2:0] S_IFG  = 3'd7;

  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

`ifdef GMII_TX_FRAMER_FCS_EN
  localparam logic [2:0] S_TAIL = S_FCS;
`else
  localparam logic [2:0] S_TAIL = S_IFG;
`endif

  // State names the work done at the next clock edge; the GMII
  // registers hold the byte already on the wire this cycle.
  logic [2:0]  state;
  logic [2:0]  pre_cnt;
  logic [15:0] byte_cnt;
  logic [15:0] cnt_inc;
  logic [15:0] ifg_cnt;
  logic        dropped;

`ifdef GMII_TX_FRAMER_FCS_EN
  logic [31:0] crc;
  logic [1:0]  fcs_idx;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  assign busy     = (state != S_IDLE);
  assign s_tready = (state == S_SFD) ||
                    (state == S_DATA) ||
                    (state == S_DROP);
  assign cnt_inc  = (byte_cnt == 16'hFFFF) ?
                    byte_cnt : byte_cnt + 16'd1;

  always_ff @(posedge gmii_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      pre_cnt    <= 3'd0;
      byte_cnt   <= 16'd0;
      ifg_cnt    <= 16'd0;
      dropped    <= 1'b0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
`ifdef GMII_TX_FRAMER_FCS_EN
      crc        <= 32'hFFFFFFFF;
      fcs_idx    <= 2'd0;
`endif
    end else begin
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      ifg_cnt    <= 16'd0;
`ifdef GMII_TX_FRAMER_FCS_EN
      fcs_idx    <= 2'd0;
`endif
      unique case (state)
        S_IDLE: begin
          if (s_tvalid) begin
            state      <= S_PRE;
            gmii_tx_en <= 1'b1;
            gmii_txd   <= 8'h55;
            pre_cnt    <= 3'd1;
            byte_cnt   <= 16'd0;
            dropped    <= 1'b0;
`ifdef GMII_TX_FRAMER_FCS_EN
            crc        <= 32'hFFFFFFFF;
`endif
          end
        end
        S_PRE: begin
          gmii_tx_en <= 1'b1;
          if (pre_cnt == 3'd7) begin
            gmii_txd <= 8'hD5;
            state    <= S_SFD;
          end else begin
            gmii_txd <= 8'h55;
            pre_cnt  <= pre_cnt + 3'd1;
          end
        end
        S_SFD, S_DATA: begin
          gmii_tx_en <= 1'b1;
          if (s_tvalid) begin
            gmii_txd   <= s_tdata;
            gmii_tx_er <= s_tuser;
            byte_cnt   <= cnt_inc;
`ifdef GMII_TX_FRAMER_FCS_EN
            crc        <= crc_byte(crc, s_tdata);
`endif
            if (s_tlast)
              state <= (cnt_inc < MIN_LEN) ? S_PAD : S_TAIL;
            else
              state <= S_DATA;
          end else begin
            // Starved mid-frame: poison the frame on the wire.
            gmii_tx_er <= 1'b1;
            underrun   <= 1'b1;
            dropped    <= 1'b1;
            state      <= S_DROP;
          end
        end
        S_PAD: begin
          gmii_tx_en <= 1'b1;
          byte_cnt   <= cnt_inc;
`ifdef GMII_TX_FRAMER_FCS_EN
          crc        <= crc_byte(crc, 8'h00);
`endif
          if (cnt_inc >= MIN_LEN)
            state <= S_TAIL;
        end
        S_FCS: begin
`ifdef GMII_TX_FRAMER_FCS_EN
          // Reflected CRC: low byte goes first, complemented.
          gmii_tx_en <= 1'b1;
          gmii_txd   <= ~crc[7:0];
          crc        <= {8'h00, crc[31:8]};
          fcs_idx    <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3)
            state <= S_IFG;
`else
          state <= S_IFG;
`endif
        end
        S_DROP: begin
          if (s_tvalid && s_tlast)
            state <= S_IFG;
        end
        S_IFG: begin
          if (ifg_cnt == 16'd0 && !dropped)
            frame_done <= 1'b1;
          if (ifg_cnt == IFG_LAST)
            state <= S_IDLE;
          else
            ifg_cnt <= ifg_cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: directed bench for gmii_tx_framer.
// Checks framing, padding, FCS (when built in), IFG, underrun and reset.
module tb_gmii_tx_framer;

  localparam int IFG  = 12;
  localparam int MINF = 60;
`ifdef GMII_TX_FRAMER_FCS_EN
  localparam int FCS_N = 4;
`else
  localparam int FCS_N = 0;
`endif
  localparam int FLEN = 8 + MINF + FCS_N;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tuser = 1'b0;
  logic       s_tready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int cap_base = 0;

  logic [7:0] cap_txd [0:1023];
  logic       cap_en  [0:1023];
  logic       cap_er  [0:1023];
  logic       cap_fd  [0:1023];
  logic       cap_ur  [0:1023];

  gmii_tx_framer #(
    .IFG_BYTES(IFG),
    .MIN_FRAME(MINF)
  ) dut (
    .gmii_tx_clk(clk),
    .reset_n(rst_n),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tuser(s_tuser),
    .s_tready(s_tready),
    .gmii_txd(gmii_txd),
    .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er),
    .busy(busy),
    .frame_done(frame_done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cyc >= cap_base && cyc - cap_base < 1024) begin
      cap_txd[cyc-cap_base] <= gmii_txd;
      cap_en[cyc-cap_base]  <= gmii_tx_en;
      cap_er[cyc-cap_base]  <= gmii_tx_er;
      cap_fd[cyc-cap_base]  <= frame_done;
      cap_ur[cyc-cap_base]  <= underrun;
    end
    cyc <= cyc + 1;
  end

`ifdef GMII_TX_FRAMER_FCS_EN
  function automatic logic [31:0] crc_upd(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  function automatic int find_en(input int from, input int to);
    for (int k = from; k < to && k < 1024; k++)
      if (cap_en[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int run_len(input int from);
    int l;
    l = 0;
    while (from + l < 1024 && cap_en[from+l] === 1'b1) l++;
    return l;
  endfunction

  function automatic int cnt_fd(input int to);
    int c;
    c = 0;
    for (int k = 0; k < to && k < 1024; k++)
      if (cap_fd[k] === 1'b1) c++;
    return c;
  endfunction

  task automatic cap_mark();
    @(posedge clk);
    cap_base = cyc;
  endtask

  task automatic src_idle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(
    input int len, input int seed, input int er_idx,
    input int stall_idx, input int stall_len
  );
    int i, st, guard;
    i = 0;
    st = stall_len;
    guard = 0;
    while (i < len && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (i == stall_idx && st > 0) begin
        s_tvalid = 1'b0;
        st--;
      end else begin
        s_tvalid = 1'b1;
        s_tdata  = 8'(seed + i);
        s_tlast  = (i == len - 1);
        s_tuser  = (i == er_idx);
        if (s_tready) i++;
      end
    end
    n_chk++;
    if (i != len) begin
      n_fail++;
      $display("FAIL send_timeout accepted %0d want %0d", i, len);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #20;
    n_chk++;
    if ({gmii_txd, gmii_tx_en, gmii_tx_er, s_tready,
         busy, frame_done, underrun} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0",
        {gmii_txd, gmii_tx_en, gmii_tx_er, s_tready,
         busy, frame_done, underrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_min_frame();
    int n, s, l, bad;
`ifdef GMII_TX_FRAMER_FCS_EN
    logic [31:0] c;
`endif
    cap_mark();
    send_frame(60, 0, -1, -1, 0);
    @(negedge clk);
    src_idle();
    repeat (30) @(negedge clk);
    @(posedge clk);
    n = cyc - cap_base;
    s = find_en(0, n);
    n_chk++;
    if (s != 1) begin
      n_fail++;
      $display("FAIL start_latency got %0d want 1", s);
    end
    if (s < 0 || s > 800) s = 0;
    bad = 0;
    for (int k = 0; k < 7; k++)
      if (cap_txd[s+k] !== 8'h55) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL preamble bad %0d want 0", bad);
    end
    n_chk++;
    if (cap_txd[s+7] !== 8'hD5) begin
      n_fail++;
      $display("FAIL sfd got %h want d5", cap_txd[s+7]);
    end
    bad = 0;
    for (int k = 0; k < 60; k++)
      if (cap_txd[s+8+k] !== 8'(k)) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL min_data bad %0d want 0", bad);
    end
    l = run_len(s);
    n_chk++;
    if (l != FLEN) begin
      n_fail++;
      $display("FAIL min_en_len got %0d want %0d", l, FLEN);
    end
`ifdef GMII_TX_FRAMER_FCS_EN
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 64; k++)
      c = crc_upd(c, cap_txd[s+8+k]);
    // DEBB20E3 is the reflected register form of residue C704DD7B.
    n_chk++;
    if (c !== 32'hDEBB20E3) begin
      n_fail++;
      $display("FAIL min_residue got %h want debb20e3", c);
    end
`endif
    n_chk++;
    if (cnt_fd(n) != 1 || cap_fd[s+FLEN] !== 1'b1) begin
      n_fail++;
      $display("FAIL min_frame_done count %0d at_end %b want 1 1",
        cnt_fd(n), cap_fd[s+FLEN]);
    end
    bad = 0;
    for (int k = 0; k < n; k++)
      if (cap_er[k] === 1'b1 || cap_ur[k] === 1'b1) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL min_no_error got %0d want 0", bad);
    end
  endtask

  task automatic test_pad();
    int n, s, l, bad;
`ifdef GMII_TX_FRAMER_FCS_EN
    logic [31:0] c;
`endif
    cap_mark();
    send_frame(10, 8'hA0, -1, -1, 0);
    @(negedge clk);
    src_idle();
    repeat (100) @(negedge clk);
    @(posedge clk);
    n = cyc - cap_base;
    s = find_en(0, n);
    if (s < 0 || s > 800) s = 0;
    bad = 0;
    for (int k = 0; k < 10; k++)
      if (cap_txd[s+8+k] !== 8'(8'hA0 + k)) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pad_data bad %0d want 0", bad);
    end
    bad = 0;
    for (int k = 10; k < 60; k++)
      if (cap_txd[s+8+k] !== 8'h00 || cap_en[s+8+k] !== 1'b1)
        bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pad_zero bad %0d want 0", bad);
    end
    l = run_len(s);
    n_chk++;
    if (l != FLEN) begin
      n_fail++;
      $display("FAIL pad_en_len got %0d want %0d", l, FLEN);
    end
`ifdef GMII_TX_FRAMER_FCS_EN
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 64; k++)
      c = crc_upd(c, cap_txd[s+8+k]);
    n_chk++;
    if (c !== 32'hDEBB20E3) begin
      n_fail++;
      $display("FAIL pad_residue got %h want debb20e3", c);
    end
`endif
  endtask

  task automatic test_tuser();
    int n, s, l, bad;
    cap_mark();
    send_frame(60, 8'h10, 5, -1, 0);
    @(negedge clk);
    src_idle();
    repeat (30) @(negedge clk);
    @(posedge clk);
    n = cyc - cap_base;
    s = find_en(0, n);
    if (s < 0 || s > 800) s = 0;
    bad = 0;
    for (int k = 0; k < FLEN; k++)
      if (cap_er[s+k] !== (k == 13)) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL tuser_er bad %0d want 0", bad);
    end
    n_chk++;
    if (cap_txd[s+13] !== 8'h15) begin
      n_fail++;
      $display("FAIL tuser_byte got %h want 15", cap_txd[s+13]);
    end
    l = run_len(s);
    n_chk++;
    if (l != FLEN || cnt_fd(n) != 1) begin
      n_fail++;
      $display("FAIL tuser_frame len %0d done %0d want %0d 1",
        l, cnt_fd(n), FLEN);
    end
  endtask

  task automatic test_back_to_back();
    int n, s1, l1, s2, l2;
    cap_mark();
    send_frame(60, 8'h20, -1, -1, 0);
    send_frame(60, 8'h40, -1, -1, 0);
    @(negedge clk);
    src_idle();
    repeat (40) @(negedge clk);
    @(posedge clk);
    n = cyc - cap_base;
    s1 = find_en(0, n);
    if (s1 < 0 || s1 > 800) s1 = 0;
    l1 = run_len(s1);
    s2 = find_en(s1 + l1, n);
    n_chk++;
    if (s2 - (s1 + l1) != IFG) begin
      n_fail++;
      $display("FAIL b2b_gap got %0d want %0d", s2 - (s1 + l1), IFG);
    end
    if (s2 < 0 || s2 > 800) s2 = 0;
    l2 = run_len(s2);
    n_chk++;
    if (cap_txd[s2] !== 8'h55 || cap_txd[s2+8] !== 8'h40) begin
      n_fail++;
      $display("FAIL b2b_second pre %h data0 %h want 55 40",
        cap_txd[s2], cap_txd[s2+8]);
    end
    n_chk++;
    if (l1 != FLEN || l2 != FLEN) begin
      n_fail++;
      $display("FAIL b2b_len got %0d %0d want %0d", l1, l2, FLEN);
    end
    n_chk++;
    if (cnt_fd(n) != 2) begin
      n_fail++;
      $display("FAIL b2b_done got %0d want 2", cnt_fd(n));
    end
  endtask

  task automatic test_underrun();
    int n, s, l, bad, bcnt, nur, ner;
    cap_mark();
    send_frame(40, 8'h60, -1, 20, 3);
    bcnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) src_idle();
      if (busy) bcnt++;
    end
    @(posedge clk);
    n = cyc - cap_base;
    n_chk++;
    if (bcnt != IFG) begin
      n_fail++;
      $display("FAIL drop_ifg busy %0d want %0d", bcnt, IFG);
    end
    s = find_en(0, n);
    if (s < 0 || s > 800) s = 0;
    l = run_len(s);
    n_chk++;
    if (l != 29) begin
      n_fail++;
      $display("FAIL ur_en_len got %0d want 29", l);
    end
    bad = 0;
    for (int k = 0; k < 20; k++)
      if (cap_txd[s+8+k] !== 8'(8'h60 + k)) bad++;
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ur_data bad %0d want 0", bad);
    end
    n_chk++;
    if (cap_er[s+28] !== 1'b1 || cap_txd[s+28] !== 8'h00 ||
        cap_ur[s+28] !== 1'b1) begin
      n_fail++;
      $display("FAIL ur_err_cycle er %b txd %h ur %b want 1 00 1",
        cap_er[s+28], cap_txd[s+28], cap_ur[s+28]);
    end
    nur = 0;
    ner = 0;
    for (int k = 0; k < n; k++) begin
      if (cap_ur[k] === 1'b1) nur++;
      if (cap_er[k] === 1'b1) ner++;
    end
    n_chk++;
    if (nur != 1 || ner != 1) begin
      n_fail++;
      $display("FAIL ur_pulses ur %0d er %0d want 1 1", nur, ner);
    end
    n_chk++;
    if (cnt_fd(n) != 0 || find_en(s + l, n) != -1) begin
      n_fail++;
      $display("FAIL ur_after done %0d en_at %0d want 0 -1",
        cnt_fd(n), find_en(s + l, n));
    end
  endtask

  task automatic test_reset_mid();
    int n, s, l;
    send_frame(60, 8'h70, -1, -1, 0);
    @(negedge clk);
    src_idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({gmii_txd, gmii_tx_en, gmii_tx_er, s_tready,
         busy, frame_done, underrun} !== 14'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got %h want 0",
        {gmii_txd, gmii_tx_en, gmii_tx_er, s_tready,
         busy, frame_done, underrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cap_mark();
    send_frame(10, 8'h80, -1, -1, 0);
    @(negedge clk);
    src_idle();
    repeat (100) @(negedge clk);
    @(posedge clk);
    n = cyc - cap_base;
    s = find_en(0, n);
    n_chk++;
    if (s != 1) begin
      n_fail++;
      $display("FAIL post_reset_start got %0d want 1", s);
    end
    if (s < 0 || s > 800) s = 0;
    l = run_len(s);
    n_chk++;
    if (cap_txd[s] !== 8'h55 || l != FLEN) begin
      n_fail++;
      $display("FAIL post_reset_frame txd %h len %0d want 55 %0d",
        cap_txd[s], l, FLEN);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_min_frame();
    test_pad();
    test_tuser();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
